// File: rtl/seq_divider_by8_if.sv
// Start/done handshake and operand/result bus for the 8-bit sequential divider.
interface seq_divider_by8_if;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] Q;
   logic [7:0] R;
   logic       busy;
   logic       done;
   logic       dbz;

   modport master (output start, A, B, input Q, R, busy, done, dbz);
   modport slave  (input start, A, B, output Q, R, busy, done, dbz);
endinterface

// File: rtl/seq_divider_by8.sv
// Sequential 8-bit restoring divider, one quotient bit per clock, start/done handshake.
// Optional two's complement mode: define SEQ_DIVIDER_SIGNED_EN.
module seq_divider_by8 (
   input  logic               clk,
   input  logic               rst,
   seq_divider_by8_if.slave   dif
);
   localparam int WIDTH = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, dvs, p, q_r, r_r;
   logic [2:0]       cnt;
   logic             dbz_r;
   logic             accept, zero_div, last_iter;
   logic [WIDTH:0]   pshift, t;
   logic             qbit;
   logic [WIDTH-1:0] p_step, sr_step, a_mag, b_mag, q_fix, r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q, neg_r;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      dif.busy  = 1'b0;
      dif.done  = 1'b0;
      case (state)
         IDLE: begin
            if (dif.start) begin
               accept    = 1'b1;
               state_nxt = zero_div ? DONE : RUN;
            end
         end
         RUN: begin
            dif.busy = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            dif.busy  = 1'b1;
            dif.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign zero_div  = (dif.B == '0);
   assign last_iter = (cnt == 3'd7);

   // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow
   always_comb begin
      pshift  = {p, sr[WIDTH-1]};
      t       = pshift - {1'b0, dvs};
      qbit    = ~t[WIDTH];
      p_step  = qbit ? t[WIDTH-1:0] : pshift[WIDTH-1:0];
      sr_step = {sr[WIDTH-2:0], qbit};
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   // -128 has no positive 8-bit form but its magnitude 0x80 is correct as unsigned
   always_comb begin
      a_mag = dif.A[WIDTH-1] ? (~dif.A + 8'd1) : dif.A;
      b_mag = dif.B[WIDTH-1] ? (~dif.B + 8'd1) : dif.B;
      q_fix = neg_q ? (~sr_step + 8'd1) : sr_step;
      r_fix = neg_r ? (~p_step + 8'd1) : p_step;
   end
`else
   always_comb begin
      a_mag = dif.A;
      b_mag = dif.B;
      q_fix = sr_step;
      r_fix = p_step;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sr    <= '0;
         dvs   <= '0;
         p     <= '0;
         cnt   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dbz_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else if (accept) begin
         if (zero_div) begin
            q_r   <= '1;
            r_r   <= dif.A;
            dbz_r <= 1'b1;
         end else begin
            sr    <= a_mag;
            dvs   <= b_mag;
            p     <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= dif.A[WIDTH-1] ^ dif.B[WIDTH-1];
            neg_r <= dif.A[WIDTH-1];
`endif
         end
      end else if (state == RUN) begin
         sr  <= sr_step;
         p   <= p_step;
         cnt <= cnt + 3'd1;
         // Results land on the DONE entry edge so they are valid with done
         if (last_iter) begin
            q_r <= q_fix;
            r_r <= r_fix;
         end
      end
   end

   assign dif.Q   = q_r;
   assign dif.R   = r_r;
   assign dif.dbz = dbz_r;
endmodule

// File: doc/seq_divider_by8.md
# seq_divider_by8

Sequential 8-bit restoring divider: the inverse datapath to the shift-and-add multiplier built on the 8-bit ripple adder. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock using a 9-bit trial subtraction. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic datapath and shares its start/done handshake style.

## Interface
- WIDTH, 8: operand, quotient and remainder width; only 8 is supported and verified.
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  8  dividend
- B  input  8  divisor
- Q  output  8  quotient
- R  output  8  remainder
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; Q/R/dbz valid
- dbz  output  1  divide-by-zero flag for the current result

## Operation
- Reset: state IDLE; Q=0, R=0, busy=0, done=0, dbz=0; internal counter and partial remainder cleared.
- States are IDLE, RUN and DONE.
- IDLE to RUN on start=1:
  - latch A into the quotient/shift register and B into the divisor register;
  - clear the 9-bit partial remainder P and the 3-bit counter;
  - clear dbz.
- IDLE to DONE on start=1 with B=0 (zero-divisor skip): Q=8'hFF, R=A, dbz=1.
- RUN, each cycle:
  - shift {P[7:0], Q[7]} into P and shift Q left;
  - form T = P - {1'b0, divisor} as a 9-bit subtraction;
  - if T[8]=0, set P=T and Q[0]=1; otherwise keep P and set Q[0]=0;
  - increment the counter; after the 8th iteration go to DONE.
- DONE: done=1 and R=P[7:0] for exactly one cycle, then IDLE.
- Q, R and dbz hold their values until the next accepted start.
- start in RUN or DONE is ignored. It is not queued.
- Operand changes after acceptance have no effect.
- Arithmetic rules: all intermediate values are unsigned. Invariant at DONE: A = Q*B + R with R < B.

## Timing
- Edge 0 samples start=1 in IDLE.
- Normal path: edges 1–8 perform iterations. done=1 in the cycle after edge 8, so latency from the start edge to the done cycle is 8 cycles. busy=1 from the cycle after edge 0 through the done cycle. IDLE is reached at edge 9.
- Zero divisor: done=1 in the cycle after edge 0 (latency 1).
- Back-to-back operation: start may be held high. The next operation is accepted at the first IDLE cycle, which is edge 9 after the previous acceptance.
- rst=1 on any edge, including mid-RUN or during done:
  - the operation aborts;
  - all outputs take their reset values on that edge;
  - no done is produced.
- rst has priority over start on the same edge.

## Configuration
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: A and B are two's complement.
  - The magnitudes are divided with the same unsigned core.
  - Quotient is negated if A[7]^B[7]; it truncates toward zero.
  - Remainder takes the sign of A.
  - Sign correction happens in the DONE entry cycle, so latency is unchanged.
  - -128 / -1 yields Q=8'h80, R=0.
  - Zero divisor yields Q=8'hFF, R=A, dbz=1.
- Undefined: purely unsigned operation and no sign logic is synthesized.

## Test plan
- A=200, B=7, start one cycle: done 8 cycles after the start edge; Q=28 (0x1C), R=4, dbz=0; busy high for 9 cycles.
- A=0xFF, B=0x01 then A=5, B=9: results Q=0xFF, R=0 then Q=0, R=5. Start is held high, so the second operation is accepted exactly at edge 9.
- A=0x2A, B=0: done in the cycle after the start edge; Q=0xFF, R=0x2A, dbz=1; the following valid division clears dbz.
- Pulse start again at cycles 3 and 8 of a running operation: both are ignored; exactly one done pulse; result is unchanged.
- Assert rst at iteration 4: on the next cycle all outputs are 0 and the state is IDLE, and no done follows. A new start then completes normally.
- With SEQ_DIVIDER_SIGNED_EN defined:
  - A=0xF9 (-7), B=0x02 gives Q=0xFD (-3), R=0xFF (-1);
  - A=0x80, B=0xFF gives Q=0x80, R=0.
